// File: rtl/nibble_serial_adder16.sv
// Nibble-serial 16-bit adder/subtractor.
// Drives an external 4-bit ripple adder one nibble per cycle, LSB first.
module nibble_serial_adder16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    input  logic        op_cin,
    input  logic        op_sub,
    output logic [3:0]  add_a,
    output logic [3:0]  add_b,
    output logic        add_cin,
    input  logic [3:0]  add_s,
    input  logic        add_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] sum,
    output logic        cout,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] sum_q;
    logic [15:0] sum_d;
    logic        carry_q;
    logic        cout_q;
    logic        ovf_q;
    logic        ovf_d;
    logic [1:0]  k_q;
    logic [3:0]  nib_a;
    logic [3:0]  nib_b;

    // Select the current nibble of each latched operand.
    always_comb begin
        nib_a = 4'h0;
        nib_b = 4'h0;
        unique case (k_q)
            2'd0: begin
                nib_a = a_q[3:0];
                nib_b = b_q[3:0];
            end
            2'd1: begin
                nib_a = a_q[7:4];
                nib_b = b_q[7:4];
            end
            2'd2: begin
                nib_a = a_q[11:8];
                nib_b = b_q[11:8];
            end
            2'd3: begin
                nib_a = a_q[15:12];
                nib_b = b_q[15:12];
            end
            default: begin
                nib_a = 4'h0;
                nib_b = 4'h0;
            end
        endcase
    end

    // Adder inputs are live only while adding; quiet otherwise.
    always_comb begin
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        if (state_q == ADD) begin
            add_a   = nib_a;
            add_b   = nib_b;
            add_cin = carry_q;
        end
    end

    // Merge the adder sum into the nibble slot being processed.
    always_comb begin
        sum_d = sum_q;
        unique case (k_q)
            2'd0: sum_d[3:0]   = add_s;
            2'd1: sum_d[7:4]   = add_s;
            2'd2: sum_d[11:8]  = add_s;
            2'd3: sum_d[15:12] = add_s;
            default: sum_d = sum_q;
        endcase
    end

    // Overflow from the operand sign bits and the top result bit.
    always_comb begin
        ovf_d = (a_q[15] == b_q[15]) & (add_s[3] != a_q[15]);
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            sum_q   <= 16'h0000;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= 2'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= op_a;
                        b_q     <= op_sub ? ~op_b : op_b;
                        carry_q <= op_sub ? 1'b1 : op_cin;
                        k_q     <= 2'd0;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    sum_q   <= sum_d;
                    carry_q <= add_cout;
                    k_q     <= k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        cout_q  <= add_cout;
                        ovf_q   <= ovf_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
